sram_resp: RTL and testbench
============================

Name: sram_resp

Overview:
- Responder (slave) end of the CPU's inst_sram/data_sram request interface.
- Serves a unified word-addressed RAM through two ports: an instruction read port and a data read/write port.
- Also serves a small MMIO register window on the data port: LEDs, switches, timer/compare, interrupt status.
- Sits under the CPU top in the SoC wrapper; drives the CPU's ext_int from the timer.
- Fixed one-cycle read latency, matching the CPU's synchronous-SRAM timing.

Parameters:
- RAM_AW, 14, word-address bits of RAM (2^14 words = 64 KiB).
- MMIO_HI, 16'hBFAF, addr[31:16] value selecting the MMIO window.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- inst_sram_en  in  1  instruction request enable
- inst_sram_wen  in  4  instruction byte write enables (ignored; port is read-only)
- inst_sram_addr  in  32  instruction byte address
- inst_sram_wdata  in  32  ignored
- inst_sram_rdata  out  32  instruction read data, valid one cycle after en
- data_sram_en  in  1  data request enable
- data_sram_wen  in  4  data byte write enables; nonzero = write
- data_sram_addr  in  32  data byte address
- data_sram_wdata  in  32  data write data
- data_sram_rdata  out  32  data read data, valid one cycle after en
- switch_in  in  8  board switches
- led_out  out  16  LED register
- ext_int  out  6  interrupt lines to CPU; bit5 = timer, bits4:0 = 0

Behaviour:
- Reset (async, rst_n low): inst_sram_rdata=0, data_sram_rdata=0, led_out=0, timer=0, cmp=0, pending=0, ext_int=0. RAM contents are not reset.
- Address decode:
  - addr[1:0] ignored.
  - Data port: addr[31:16]==MMIO_HI selects MMIO; all other addresses select RAM at word index addr[RAM_AW+1:2] (upper bits alias).
  - Instruction port always selects RAM.
- Latency:
  - An en=1 request in cycle N yields rdata in cycle N+1.
  - With en=0, the rdata register holds its last value.
  - No stall or handshake: every request is accepted.
- RAM writes: with data_sram_en=1, each wen[i] writes byte lane i (wdata[8i+7:8i]) at the clock edge.
- Read-first ordering:
  - A data write with en=1 returns the pre-write word on data_sram_rdata.
  - A same-cycle inst read of the same word also returns the old word.
  - The new value is visible from cycle N+1.
- MMIO map (offset = addr[15:0]); byte enables apply to writes:
  - 0xF000 LED: RW, 16 bits; upper 16 bits read 0.
  - 0xF004 SWITCH: RO; reads {24'b0, switch_in} sampled at the request edge; writes ignored.
  - 0xF008 TIMER: RW, 32 bits; increments by 1 every cycle and wraps 0xFFFFFFFF->0.
  - 0xF00C CMP: RW, 32 bits.
  - 0xF010 INT_STATUS: bit0 = pending; writing 1 to bit0 clears it; other bits read 0.
  - Any other offset reads 0; writes are ignored.
- Timer write vs increment in the same cycle: the written value loads and does not increment that cycle.
- Interrupt:
  - pending sets when cmp!=0 and timer==cmp (value before increment).
  - A set and a write-1-clear in the same cycle: set wins.
  - ext_int[5] = pending, registered.
- Reset asserted mid-operation clears all registers immediately. An in-flight read result is discarded (rdata=0).

Optional Feature:
- Macro: SRAM_RESP_TIMER_EN.
- Defined: TIMER, CMP and INT_STATUS are implemented as above.
- Undefined: those three offsets read 0 and ignore writes; ext_int is tied to 0; no timer logic is synthesised.

Decomposition:
- Shared package sram_resp_pkg: MMIO_HI default, register offsets (LED_OFF, SW_OFF, TIMER_OFF, CMP_OFF, INTST_OFF), byte-merge function (old word, wdata, wen -> new word).
- One sub-module, sram_resp_mmio: holds the LED/timer/cmp/pending registers and the MMIO read mux.
- Top level keeps the RAM array, address decode and rdata registers.

Test Plan:
- Reset mid-run: rst_n low while timer=0x1234 and led=0xFFFF -> led_out=0, ext_int=0 and both rdata=0 in the same cycle.
- Byte write/readback: write 0x11223344 to 0x00000100 (wen=4'hF), then wen=4'b0010 with wdata=0x0000AA00; read 0x100 -> 0x1122AA44 one cycle after en. Inst read of 0x100 -> same value.
- Same-address collision: data write 0xDEADBEEF to 0x200 and inst read of 0x200 in the same cycle -> inst_sram_rdata = old word. Next-cycle inst read -> 0xDEADBEEF.
- MMIO: write 0xBFAFF000 = 0x0000A5A5 -> led_out=0xA5A5. With switch_in=0x3C, read 0xBFAFF004 -> 0x0000003C. Read 0xBFAFF0F0 -> 0.
- Timer interrupt: write TIMER=10 and CMP=15 -> ext_int[5] rises 6 cycles later. Write 1 to INT_STATUS -> ext_int[5] falls. Repeat with the clear landing on the match cycle -> pending stays 1.
- Timer wrap and write priority: write TIMER=0xFFFFFFFE and read it back over 3 cycles -> wraps through 0. A TIMER write on an increment cycle loads the written value exactly.

Source files
------------

// File: rtl/sram_resp_pkg.sv
// Shared definitions for the sram_resp responder: the MMIO window select,
// the register offsets and the byte-lane merge used for register writes.
package sram_resp_pkg;

  localparam logic [15:0] MMIO_HI_DEF = 16'hBFAF;

  localparam logic [15:0] LED_OFF   = 16'hF000;
  localparam logic [15:0] SW_OFF    = 16'hF004;
  localparam logic [15:0] TIMER_OFF = 16'hF008;
  localparam logic [15:0] CMP_OFF   = 16'hF00C;
  localparam logic [15:0] INTST_OFF = 16'hF010;

  // Data-port request as seen by the MMIO block. The en field is already
  // qualified with the window decode.
  typedef struct packed {
    logic        en;
    logic [3:0]  wen;
    logic [15:0] off;
    logic [31:0] wdata;
  } mmio_req_t;

  // Replace each byte lane of old_w whose enable is set with the wdata lane.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_w,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  wen);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++)
      if (wen[b]) r[8*b +: 8] = wdata[8*b +: 8];
    return r;
  endfunction

endpackage

// File: rtl/sram_resp_if.sv
// CPU-side inst_sram / data_sram request bus. The CPU is the master and
// sram_resp is the slave; read data comes back one cycle after en.
interface sram_resp_if;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_wen;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;

  modport master (
    output inst_sram_en, inst_sram_wen, inst_sram_addr, inst_sram_wdata,
    output data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
    input  inst_sram_rdata, data_sram_rdata
  );

  modport slave (
    input  inst_sram_en, inst_sram_wen, inst_sram_addr, inst_sram_wdata,
    input  data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
    output inst_sram_rdata, data_sram_rdata
  );
endinterface

// File: rtl/sram_resp_mmio.sv
// MMIO register window of sram_resp: LED register, switch read-back and,
// when SRAM_RESP_TIMER_EN is defined, the free-running timer, compare
// register and interrupt-pending flag. rdata is the combinational read mux
// of the current (pre-edge) register values; the top registers it.
module sram_resp_mmio
  import sram_resp_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  mmio_req_t   req,
  input  logic [7:0]  switch_in,
  output logic [31:0] rdata,
  output logic [15:0] led_out,
  output logic [5:0]  ext_int
);

  logic        wr;
  logic [31:0] led_new;
  logic        unused_led_hi;

  assign wr            = req.en && (req.wen != 4'b0000);
  assign led_new       = byte_merge({16'h0000, led_out}, req.wdata, req.wen);
  assign unused_led_hi = ^led_new[31:16];

  // LED register: byte-enabled write of the low half-word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        led_out <= '0;
    else if (wr && req.off == LED_OFF) led_out <= led_new[15:0];
  end

`ifdef SRAM_RESP_TIMER_EN
  logic [31:0] timer;
  logic [31:0] cmp;
  logic        pending;
  logic        timer_wr;
  logic        cmp_wr;
  logic        int_clr;
  logic        int_set;

  assign timer_wr = wr && req.off == TIMER_OFF;
  assign cmp_wr   = wr && req.off == CMP_OFF;
  assign int_clr  = wr && req.off == INTST_OFF && req.wen[0] && req.wdata[0];
  // Compare against the pre-increment value; cmp==0 disables the match.
  assign int_set  = (cmp != 32'h0) && (timer == cmp);

  // Timer: a software write takes the cycle instead of the increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        timer <= '0;
    else if (timer_wr) timer <= byte_merge(timer, req.wdata, req.wen);
    else               timer <= timer + 32'd1;
  end

  // Compare register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      cmp <= '0;
    else if (cmp_wr) cmp <= byte_merge(cmp, req.wdata, req.wen);
  end

  // Pending flag: a match in the same cycle as a clear keeps it set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending <= 1'b0;
    else        pending <= int_set | (pending & ~int_clr);
  end

  assign ext_int = {pending, 5'b00000};

  // Register read mux.
  always_comb begin
    rdata = '0;
    case (req.off)
      LED_OFF:   rdata = {16'h0000, led_out};
      SW_OFF:    rdata = {24'h000000, switch_in};
      TIMER_OFF: rdata = timer;
      CMP_OFF:   rdata = cmp;
      INTST_OFF: rdata = {31'h0, pending};
      default:   rdata = '0;
    endcase
  end
`else
  assign ext_int = '0;

  // Register read mux; timer offsets fall into the read-as-zero default.
  always_comb begin
    rdata = '0;
    case (req.off)
      LED_OFF: rdata = {16'h0000, led_out};
      SW_OFF:  rdata = {24'h000000, switch_in};
      default: rdata = '0;
    endcase
  end
`endif

endmodule

// File: rtl/sram_resp.sv
// sram_resp: slave end of the CPU inst_sram/data_sram interface. Holds a
// unified word-addressed RAM (read-only instruction port, byte-writable data
// port), decodes the MMIO window on the data port and registers both read
// results for a fixed one-cycle latency. Reads are read-first against a
// same-edge write. Optional timer/interrupt: SRAM_RESP_TIMER_EN.
module sram_resp
  import sram_resp_pkg::*;
#(
  parameter int          RAM_AW  = 14,
  parameter logic [15:0] MMIO_HI = MMIO_HI_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  sram_resp_if.slave  bus,
  input  logic [7:0]  switch_in,
  output logic [15:0] led_out,
  output logic [5:0]  ext_int
);

  logic [31:0]       ram [0:(1<<RAM_AW)-1];

  logic [RAM_AW-1:0] d_idx;
  logic [RAM_AW-1:0] i_idx;
  logic              d_mmio;
  logic              d_ram_we;
  mmio_req_t         mreq;
  logic [31:0]       mmio_rdata;
  logic              unused_inst;

  assign d_idx    = bus.data_sram_addr[RAM_AW+1:2];
  assign i_idx    = bus.inst_sram_addr[RAM_AW+1:2];
  assign d_mmio   = bus.data_sram_addr[31:16] == MMIO_HI;
  assign d_ram_we = bus.data_sram_en && !d_mmio && (bus.data_sram_wen != 4'b0000);

  // The instruction port never writes; upper address bits alias.
  assign unused_inst = ^{bus.inst_sram_wen, bus.inst_sram_wdata,
                         bus.inst_sram_addr[1:0], bus.inst_sram_addr[31:RAM_AW+2]};

  assign mreq = '{en:    bus.data_sram_en && d_mmio,
                  wen:   bus.data_sram_wen,
                  off:   bus.data_sram_addr[15:0],
                  wdata: bus.data_sram_wdata};

  sram_resp_mmio u_mmio (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (mreq),
    .switch_in (switch_in),
    .rdata     (mmio_rdata),
    .led_out   (led_out),
    .ext_int   (ext_int)
  );

  // RAM byte-lane writes from the data port (contents are not reset).
  always_ff @(posedge clk) begin
    if (d_ram_we)
      for (int b = 0; b < 4; b++)
        if (bus.data_sram_wen[b])
          ram[d_idx][8*b +: 8] <= bus.data_sram_wdata[8*b +: 8];
  end

  // Instruction read register: old word on a same-edge write, holds when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                bus.inst_sram_rdata <= '0;
    else if (bus.inst_sram_en) bus.inst_sram_rdata <= ram[i_idx];
  end

  // Data read register: MMIO mux or pre-write RAM word, holds when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                bus.data_sram_rdata <= '0;
    else if (bus.data_sram_en) bus.data_sram_rdata <= d_mmio ? mmio_rdata : ram[d_idx];
  end

endmodule

// File: tb/tb_sram_resp.sv
// Scoreboard bench for sram_resp: each request pushes its expected read data,
// monitors pop and compare one cycle after the request was accepted.
module tb_sram_resp;

  localparam logic [31:0] A_LED   = 32'hBFAF_F000;
  localparam logic [31:0] A_SW    = 32'hBFAF_F004;
  localparam logic [31:0] A_TIMER = 32'hBFAF_F008;
  localparam logic [31:0] A_CMP   = 32'hBFAF_F00C;
  localparam logic [31:0] A_INTST = 32'hBFAF_F010;

  typedef struct {
    logic [31:0] exp;
    bit          chk;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [7:0]  sw;
  logic [15:0] led;
  logic [5:0]  ext_int;

  exp_t dq[$];
  exp_t iq[$];
  exp_t de, ie;
  logic d_pend, i_pend;
  int   errors = 0;
  int   checks = 0;

  sram_resp_if bus();

  sram_resp dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .switch_in (sw),
    .led_out   (led),
    .ext_int   (ext_int)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Track which ports accepted a request at the last edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_pend <= 1'b0;
      i_pend <= 1'b0;
    end else begin
      d_pend <= bus.data_sram_en;
      i_pend <= bus.inst_sram_en;
    end
  end

  // Data-port monitor.
  always @(negedge clk) begin
    if (d_pend) begin
      if (dq.size() == 0) begin
        checks++; errors++;
        $display("FAIL data_queue_empty: got response expected none");
      end else begin
        de = dq.pop_front();
        if (de.chk) check(de.name, bus.data_sram_rdata, de.exp);
      end
    end
  end

  // Instruction-port monitor.
  always @(negedge clk) begin
    if (i_pend) begin
      if (iq.size() == 0) begin
        checks++; errors++;
        $display("FAIL inst_queue_empty: got response expected none");
      end else begin
        ie = iq.pop_front();
        if (ie.chk) check(ie.name, bus.inst_sram_rdata, ie.exp);
      end
    end
  end

  // One bus cycle: drive, push expectations, wait for the accepting edge.
  task automatic cyc(input bit den, input logic [3:0] wen, input logic [31:0] daddr,
                     input logic [31:0] wdata, input logic [31:0] dexp, input bit dchk,
                     input bit ien, input logic [31:0] iaddr, input logic [31:0] iexp,
                     input bit ichk, input string nm);
    bus.data_sram_en    = den;
    bus.data_sram_wen   = wen;
    bus.data_sram_addr  = daddr;
    bus.data_sram_wdata = wdata;
    bus.inst_sram_en    = ien;
    bus.inst_sram_addr  = iaddr;
    if (den) dq.push_back('{dexp, dchk, {nm, "/d"}});
    if (ien) iq.push_back('{iexp, ichk, {nm, "/i"}});
    @(posedge clk); #1;
    bus.data_sram_en = 1'b0;
    bus.inst_sram_en = 1'b0;
    bus.data_sram_wen = 4'h0;
  endtask

  task automatic dwr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] wen,
                     input logic [31:0] old, input bit chk, input string nm);
    cyc(1'b1, wen, a, d, old, chk, 1'b0, 32'h0, 32'h0, 1'b0, nm);
  endtask

  task automatic drd(input logic [31:0] a, input logic [31:0] exp, input string nm);
    cyc(1'b1, 4'h0, a, 32'h0, exp, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, nm);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bus.data_sram_en = 0; bus.data_sram_wen = 0; bus.data_sram_addr = 0; bus.data_sram_wdata = 0;
    bus.inst_sram_en = 0; bus.inst_sram_wen = 0; bus.inst_sram_addr = 0; bus.inst_sram_wdata = 0;
    sw = 8'h00;
    #2 rst_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    check("rst_inst_rdata", bus.inst_sram_rdata, 32'h0);
    check("rst_data_rdata", bus.data_sram_rdata, 32'h0);
    check("rst_led", {16'h0, led}, 32'h0);
    check("rst_ext_int", {26'h0, ext_int}, 32'h0);
    rst_n = 1'b1;
    idle(1);

    // Byte writes, read-first return, alias and ignored low address bits.
    dwr(32'h100, 32'h11223344, 4'hF, 32'h0, 1'b0, "bw_full");
    dwr(32'h100, 32'h0000AA00, 4'b0010, 32'h11223344, 1'b1, "bw_lane1_old");
    cyc(1'b1, 4'h0, 32'h100, 32'h0, 32'h1122AA44, 1'b1, 1'b1, 32'h100, 32'h1122AA44, 1'b1, "bw_read");
    cyc(1'b1, 4'h0, 32'h0001_0103, 32'h0, 32'h1122AA44, 1'b1,
        1'b1, 32'h0004_0102, 32'h1122AA44, 1'b1, "alias");
    idle(2);
    check("hold_data", bus.data_sram_rdata, 32'h1122AA44);
    check("hold_inst", bus.inst_sram_rdata, 32'h1122AA44);

    // Same-word write and instruction read in one cycle.
    dwr(32'h200, 32'h0BADF00D, 4'hF, 32'h0, 1'b0, "col_init");
    cyc(1'b1, 4'hF, 32'h200, 32'hDEADBEEF, 32'h0BADF00D, 1'b1,
        1'b1, 32'h200, 32'h0BADF00D, 1'b1, "collide");
    cyc(1'b1, 4'h0, 32'h200, 32'h0, 32'hDEADBEEF, 1'b1, 1'b1, 32'h200, 32'hDEADBEEF, 1'b1, "col_after");

    // MMIO window.
    dwr(32'h0000_F000, 32'h600DCAFE, 4'hF, 32'h0, 1'b0, "ram_f000");
    dwr(A_LED, 32'h0000A5A5, 4'hF, 32'h0, 1'b1, "led_wr");
    check("led_out", {16'h0, led}, 32'h0000A5A5);
    dwr(A_LED, 32'h000000FF, 4'b0001, 32'h0000A5A5, 1'b1, "led_byte");
    check("led_byte_out", {16'h0, led}, 32'h0000A5FF);
    drd(A_LED, 32'h0000A5FF, "led_rd");
    drd(32'h0000_F000, 32'h600DCAFE, "mmio_not_ram");
    drd(32'hBFAE_F000, 32'h600DCAFE, "near_window_ram");
    sw = 8'h3C;
    drd(A_SW, 32'h0000003C, "switch_rd");
    dwr(A_SW, 32'hFFFFFFFF, 4'hF, 32'h0000003C, 1'b1, "switch_wr");
    drd(A_SW, 32'h0000003C, "switch_ro");
    dwr(32'hBFAF_F0F0, 32'h12345678, 4'hF, 32'h0, 1'b1, "hole_wr");
    drd(32'hBFAF_F0F0, 32'h0, "hole_rd");

`ifdef SRAM_RESP_TIMER_EN
    // Interrupt rises six edges after the TIMER write.
    dwr(A_TIMER, 32'd10, 4'hF, 32'h0, 1'b0, "t10");
    dwr(A_CMP, 32'd15, 4'hF, 32'h0, 1'b1, "c15");
    idle(4);
    check("int_early", {26'h0, ext_int}, 32'h0);
    idle(1);
    check("int_rise", {26'h0, ext_int}, 32'h20);
    drd(A_INTST, 32'h1, "intst_rd");
    dwr(A_INTST, 32'h1, 4'hF, 32'h1, 1'b1, "int_clr");
    check("int_fall", {26'h0, ext_int}, 32'h0);
    // Clear lands on the match edge: set wins.
    dwr(A_TIMER, 32'd100, 4'hF, 32'h0, 1'b0, "t100");
    dwr(A_CMP, 32'd103, 4'hF, 32'd15, 1'b1, "c103");
    idle(2);
    dwr(A_INTST, 32'h1, 4'hF, 32'h0, 1'b1, "clr_on_match");
    check("set_wins", {26'h0, ext_int}, 32'h20);
    dwr(A_INTST, 32'h1, 4'hF, 32'h1, 1'b1, "int_clr2");
    check("int_fall2", {26'h0, ext_int}, 32'h0);
    // Wrap and write priority.
    dwr(A_TIMER, 32'hFFFFFFFE, 4'hF, 32'h0, 1'b0, "t_wrap");
    drd(A_TIMER, 32'hFFFFFFFE, "wrap0");
    drd(A_TIMER, 32'hFFFFFFFF, "wrap1");
    drd(A_TIMER, 32'h00000000, "wrap2");
    dwr(A_TIMER, 32'h55, 4'hF, 32'h1, 1'b1, "t55");
    drd(A_TIMER, 32'h55, "t_load_exact");
    dwr(A_TIMER, 32'h0000AB00, 4'b0010, 32'h56, 1'b1, "t_byte");
    drd(A_TIMER, 32'h0000AB56, "t_byte_rd");
    drd(A_CMP, 32'd103, "cmp_rd");
`else
    dwr(A_TIMER, 32'h1234, 4'hF, 32'h0, 1'b1, "timer_off_wr");
    dwr(A_CMP, 32'h1234, 4'hF, 32'h0, 1'b1, "cmp_off_wr");
    drd(A_TIMER, 32'h0, "timer_off_rd");
    drd(A_CMP, 32'h0, "cmp_off_rd");
    drd(A_INTST, 32'h0, "intst_off_rd");
    check("ext_int_off", {26'h0, ext_int}, 32'h0);
`endif

    // Reset in the middle of activity discards the in-flight read.
    dwr(A_TIMER, 32'h1234, 4'hF, 32'h0, 1'b0, "pre_rst_t");
    dwr(A_LED, 32'h0000FFFF, 4'hF, 32'h0, 1'b0, "pre_rst_led");
    check("pre_rst_led_out", {16'h0, led}, 32'h0000FFFF);
    bus.data_sram_en = 1'b1; bus.data_sram_addr = 32'h100;
    bus.inst_sram_en = 1'b1; bus.inst_sram_addr = 32'h200;
    @(posedge clk); #1;
    bus.data_sram_en = 1'b0; bus.inst_sram_en = 1'b0;
    check("pre_rst_data", bus.data_sram_rdata, 32'h1122AA44);
    rst_n = 1'b0;
    #1;
    check("mid_rst_data", bus.data_sram_rdata, 32'h0);
    check("mid_rst_inst", bus.inst_sram_rdata, 32'h0);
    check("mid_rst_led", {16'h0, led}, 32'h0);
    check("mid_rst_ext_int", {26'h0, ext_int}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    drd(A_LED, 32'h0, "post_rst_led");
`ifdef SRAM_RESP_TIMER_EN
    drd(A_CMP, 32'h0, "post_rst_cmp");
`endif
    cyc(1'b1, 4'h0, 32'h100, 32'h0, 32'h1122AA44, 1'b1,
        1'b1, 32'h200, 32'hDEADBEEF, 1'b1, "ram_kept");
    idle(2);
    check("dq_drained", dq.size(), 32'd0);
    check("iq_drained", iq.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
